// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with a main slot, a skid slot, a synchronous flush and a saturating squash counter.
// Latency one cycle; ready_out is registered (skid empty), so a stall never reaches upstream combinationally.
module pipe_stage_reg #(
  parameter int CTRL_W         = 12,
  parameter int DATA_W         = 64,
  parameter int CNT_W          = 8,
  parameter bit CLEAR_ON_FLUSH = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  squash_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_vld;
  logic              skid_vld;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;

  logic              accept;
  logic              emit;
  logic [1:0]        squash_inc;
  logic [CNT_W+1:0]  squash_sum;

  assign ready_out = ~skid_vld;
  assign valid_out = main_vld;
  assign ctrl_out  = main_vld ? main_ctrl : '0;
  assign data_out  = main_data;
  assign occupancy = {1'b0, main_vld} + {1'b0, skid_vld};

  assign accept = valid_in & ~skid_vld;
  assign emit   = main_vld & ready_in;

  // An emit that coincides with flush still reaches the consumer, so it is not a squash.
  assign squash_inc = {1'b0, main_vld & ~ready_in} + {1'b0, skid_vld} + {1'b0, accept};
  assign squash_sum = (CNT_W+2)'(squash_cnt) + (CNT_W+2)'(squash_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld   <= 1'b0;
      skid_vld   <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      main_data  <= '0;
      skid_data  <= '0;
      squash_cnt <= '0;
    end else if (flush) begin
      main_vld  <= 1'b0;
      skid_vld  <= 1'b0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      if (CLEAR_ON_FLUSH) begin
        main_data <= '0;
        skid_data <= '0;
      end
      if (squash_sum > (CNT_W+2)'(CNT_MAX)) begin
        squash_cnt <= CNT_MAX;
      end else begin
        squash_cnt <= squash_sum[CNT_W-1:0];
      end
    end else if (skid_vld) begin
      // ready_out is low here, so the only possible move is skid to main.
      if (emit) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
        skid_vld  <= 1'b0;
      end
    end else if (!main_vld || emit) begin
      main_vld <= accept;
      if (accept) begin
        main_ctrl <= ctrl_in;
        main_data <= data_in;
      end
    end else if (accept) begin
      skid_vld  <= 1'b1;
      skid_ctrl <= ctrl_in;
      skid_data <= data_in;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized scoreboard bench: two parameterisations driven in lockstep against a FIFO-level model.
module tb_pipe_stage_reg;

  typedef struct {
    logic [11:0] c;
    logic [63:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b0;
  logic [11:0] ctrl_in = '0;
  logic [63:0] data_in = '0;

  logic        ready_a, valid_a, ready_b, valid_b;
  logic [11:0] ctrl_a, ctrl_b;
  logic [63:0] data_a, data_b;
  logic [1:0]  occ_a, occ_b;
  logic [7:0]  cnt_a_out;
  logic [1:0]  cnt_b_out;

  ent_t        q[$];
  int          cnt_a = 0;
  int          cnt_b = 0;
  logic [63:0] hold_a = '0;
  logic [63:0] hold_b = '0;
  int          n_vec = 0;
  int          n_err = 0;

  pipe_stage_reg #(.CTRL_W(12), .DATA_W(64), .CNT_W(8), .CLEAR_ON_FLUSH(1'b0)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .ready_out(ready_a),
    .ctrl_in(ctrl_in), .data_in(data_in), .valid_out(valid_a), .ready_in(ready_in),
    .ctrl_out(ctrl_a), .data_out(data_a), .occupancy(occ_a), .squash_cnt(cnt_a_out)
  );

  pipe_stage_reg #(.CTRL_W(12), .DATA_W(64), .CNT_W(2), .CLEAR_ON_FLUSH(1'b1)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .ready_out(ready_b),
    .ctrl_in(ctrl_in), .data_in(data_in), .valid_out(valid_b), .ready_in(ready_in),
    .ctrl_out(ctrl_b), .data_out(data_b), .occupancy(occ_b), .squash_cnt(cnt_b_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected outputs come from the model FIFO: head entry, or the held payload when empty.
  task automatic check_dut(input string tag, input logic v, input logic r, input logic [1:0] occ,
                           input logic [7:0] cnt, input logic [11:0] c, input logic [63:0] d,
                           input int ecnt, input logic [63:0] ehold);
    int sz;
    sz = q.size();
    check({tag, ".valid_out"}, 64'(v), 64'(sz > 0));
    check({tag, ".ready_out"}, 64'(r), 64'(sz < 2));
    check({tag, ".occupancy"}, 64'(occ), 64'(sz));
    check({tag, ".squash_cnt"}, 64'(cnt), 64'(ecnt));
    check({tag, ".ctrl_out"}, 64'(c), (sz > 0) ? 64'(q[0].c) : 64'(0));
    check({tag, ".data_out"}, d, (sz > 0) ? q[0].d : ehold);
  endtask

  task automatic check_both(input string tag);
    check_dut({tag, "_A"}, valid_a, ready_a, occ_a, cnt_a_out, ctrl_a, data_a, cnt_a, hold_a);
    check_dut({tag, "_B"}, valid_b, ready_b, occ_b, {6'b0, cnt_b_out}, ctrl_b, data_b, cnt_b, hold_b);
  endtask

  always @(negedge clk) check_both("mon");

  task automatic model_reset();
    q.delete();
    cnt_a = 0;
    cnt_b = 0;
    hold_a = '0;
    hold_b = '0;
  endtask

  task automatic model_step();
    bit acc, em;
    int sq;
    acc = valid_in && (q.size() < 2);
    em  = (q.size() > 0) && ready_in;
    if (flush) begin
      sq = q.size() - (em ? 1 : 0) + (acc ? 1 : 0);
      cnt_a = (cnt_a + sq > 255) ? 255 : cnt_a + sq;
      cnt_b = (cnt_b + sq > 3) ? 3 : cnt_b + sq;
      q.delete();
      hold_b = '0;
    end else begin
      if (em) void'(q.pop_front());
      if (acc) q.push_back('{c: ctrl_in, d: data_in});
      if (q.size() > 0) begin
        hold_a = q[0].d;
        hold_b = q[0].d;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [11:0] c, input logic [63:0] d,
                     input logic r, input logic f);
    valid_in = v;
    ctrl_in  = c;
    data_in  = d;
    ready_in = r;
    flush    = f;
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic sync_reset();
    valid_in = 1'b0;
    flush    = 1'b0;
    rst      = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] d33;
    model_reset();
    repeat (2) @(negedge clk);
    check_both("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 1; i <= 10; i++) cyc(1'b1, 12'(i), rnd64(), 1'b1, 1'b0);
    cyc(1'b0, 12'h0, 64'h0, 1'b1, 1'b0);
    cyc(1'b0, 12'h0, 64'h0, 1'b1, 1'b0);

    cyc(1'b1, 12'h011, rnd64(), 1'b0, 1'b0);
    cyc(1'b1, 12'h022, rnd64(), 1'b0, 1'b0);
    d33 = rnd64();
    repeat (2) cyc(1'b1, 12'h033, d33, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 12'h033, d33, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 12'h0, 64'h0, 1'b1, 1'b0);

    cyc(1'b1, 12'h0a1, rnd64(), 1'b0, 1'b0);
    cyc(1'b1, 12'h0a2, rnd64(), 1'b0, 1'b0);
    cyc(1'b0, 12'h0, 64'h0, 1'b0, 1'b1);
    cyc(1'b0, 12'h0, 64'h0, 1'b0, 1'b0);

    cyc(1'b1, 12'h044, rnd64(), 1'b0, 1'b0);
    cyc(1'b1, 12'h055, rnd64(), 1'b1, 1'b1);
    cyc(1'b0, 12'h0, 64'h0, 1'b1, 1'b0);

    sync_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 12'(12'h100 + k), rnd64(), 1'b0, 1'b0);
      cyc(1'b1, 12'(12'h200 + k), rnd64(), 1'b0, 1'b0);
      cyc(1'b0, 12'h0, 64'h0, 1'b0, 1'b1);
    end
    cyc(1'b0, 12'h0, 64'h0, 1'b0, 1'b0);

    for (int n = 0; n < 500; n++) begin
      cyc($urandom_range(0, 3) != 0, 12'($urandom), rnd64(),
          $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset mid-cycle with both slots occupied.
    cyc(1'b1, 12'h0e1, rnd64(), 1'b0, 1'b0);
    cyc(1'b1, 12'h0e2, rnd64(), 1'b0, 1'b0);
    cyc(1'b1, 12'h0e3, rnd64(), 1'b0, 1'b0);
    valid_in = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_both("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) cyc(1'b1, 12'(12'h300 + i), rnd64(), 1'b1, 1'b0);
    cyc(1'b0, 12'h0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register for the 8-bit core's inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It adds a valid/ready handshake with a two-entry skid buffer, so back-pressure stalls do not need a combinational path upstream. It also adds a synchronous flush that converts in-flight entries into bubbles, and a saturating counter of squashed instructions for hazard-unit debug. Control and payload fields are separated so that a flush always zeroes control while payload retention is configurable.

## Interface
- CTRL_W, 12, width of control bundle (jType, aluOp, aluSrc, mem/WB enables); all-zero means NOP
- DATA_W, 64, width of payload bundle (PC+1, addresses, operands, register indices)
- CNT_W, 8, width of squash counter
- CLEAR_ON_FLUSH, 0, 1: payload slots zeroed on flush; 0: payload retained
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all held and incoming entries
- valid_in  in  1  upstream entry valid
- ready_out  out  1  stage can accept (registered, = skid slot empty)
- ctrl_in  in  CTRL_W  upstream control bundle
- data_in  in  DATA_W  upstream payload bundle
- valid_out  out  1  output slot valid (registered)
- ready_in  in  1  downstream accepts
- ctrl_out  out  CTRL_W  output control; forced 0 whenever valid_out=0
- data_out  out  DATA_W  output payload
- occupancy  out  2  entries held, 0..2
- squash_cnt  out  CNT_W  saturating count of entries discarded by flush

## Operation
- Two slots: main (drives outputs) and skid. accept = valid_in & ready_out; emit = valid_out & ready_in.
- Reset (async): both slots invalid, all ctrl/data regs 0, ready_out=1, valid_out=0, ctrl_out=0, data_out=0, occupancy=0, squash_cnt=0.
- No flush, per rising edge:
  - main empty: accept loads main.
  - main full, emit, skid empty: accept loads main; no accept empties main.
  - main full, no emit, accept: input loads skid; ready_out=0 next cycle.
  - skid full, emit: skid moves to main, skid empties, ready_out=1 next cycle. No accept is possible because ready_out=0.
  - skid full, no emit: hold all.
- Flush (highest priority):
  - both slots invalid, all ctrl regs 0.
  - data regs zeroed if CLEAR_ON_FLUSH=1, else retained.
  - An accepted input beat in the same cycle is consumed and discarded.
  - squash_cnt += (main valid & ~ready_in) + skid valid + accept, saturating at 2^CNT_W−1.
  - An emit coinciding with flush completes at the consumer and is not counted.
- occupancy = main valid + skid valid.
- Payload passes unmodified; no arithmetic beyond squash_cnt (saturating, never wraps).

## Timing
- Latency: accept at edge N → valid_out high after edge N; data visible cycle N+1.
- Throughput: one entry per cycle with ready_in held high; skid never fills.
- ready_out and valid_out are pure register outputs, with no combinational path from ready_in or valid_in. Skid handles the one-cycle ready lag.
- Order preserved: main always older than skid.
- Flush takes effect at the edge it is sampled; valid_out=0 and ready_out=1 the following cycle.
- Reset asserted mid-transfer drops all entries immediately, without waiting for a clock. squash_cnt is cleared, not incremented.

## Test plan
- Reset: rst=1 mid-stream with 2 entries held → outputs immediately 0, ready_out=1, occupancy=0, squash_cnt=0.
- Streaming: ready_in=1, push ctrl 0x001..0x00A back-to-back → ctrl_out 0x001..0x00A on consecutive cycles, one-cycle latency, occupancy never >1.
- Back-pressure: ready_in=0, push 0x011, 0x022 → occupancy=2, ready_out=0, third input held. Raise ready_in → 0x011 then 0x022 emitted in order, ready_out=1 one cycle after skid drains.
- Flush with full stage: 2 held, valid_in=0, ready_in=0, flush=1 → valid_out=0, ctrl_out=0, squash_cnt +2. Data retained (CLEAR_ON_FLUSH=0), zero (=1).
- Flush with emit and accept: main valid, ready_in=1, valid_in=1, flush=1 → downstream takes main, input dropped, squash_cnt +1, occupancy=0.
- Saturation: CNT_W=2, three flushes each squashing 2 → squash_cnt stops at 3.
